wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter VLANES, default 4, meaning 32-bit columns per vector register.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 4, meaning idle cycles before a partial vector buffer self-commits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 WB_MemData, WB_ALUResult, WB_sbox, WB_rcon  input  32 each  result candidates from the MEM/WB register.
REQ-006 WB_rd  input  5  destination register index (scalar or vector).
REQ-007 WB_MemToReg  input  2  result select: 00 ALU, 01 MemData, 10 sbox, 11 rcon.
REQ-008 WB_RegWrite, WB_VRegWrite, WB_colwrite  input  1 each  scalar write, vector write, column-granular vector write.
REQ-009 WB_columna  input  2  target column for colwrite.
REQ-010 wb_flush  input  1  force commit of any partial vector buffer.
REQ-011 rf_we, rf_waddr(5), rf_wdata(32)  output  scalar register-file write port.
REQ-012 vrf_we, vrf_waddr(5), vrf_wdata(128), vrf_wmask(4)  output  vector register-file write port; mask bit i enables bits [32i+31:32i].
REQ-013 vbusy  output  1  high while the column buffer holds uncommitted data.

Function
REQ-014 Result word SHALL be selected by WB_MemToReg per REQ-007, combinationally.
REQ-015 Scalar: WB_RegWrite=1 and WB_rd!=0 SHALL produce rf_we=1, rf_waddr=WB_rd, rf_wdata=result on the next cycle (latency 1); rd=0 SHALL be dropped.
REQ-016 All write-port outputs SHALL be registered; rf_we and vrf_we SHALL be single-cycle pulses.
REQ-017 FSM states SHALL be IDLE, COLLECT, DRAIN.
REQ-018 IDLE + colwrite&VRegWrite: buffer lane WB_columna <= result, mask <= that bit only, vrd <= WB_rd, go COLLECT.
REQ-019 IDLE + VRegWrite&!colwrite (splat): next cycle vrf_we=1, vrf_wdata=result replicated in 4 lanes, vrf_wmask=1111, vrf_waddr=WB_rd; stay IDLE.
REQ-020 COLLECT + colwrite with same vrd: merge lane (rewrite of a set lane SHALL overwrite); when mask reaches 1111, commit next cycle with mask 1111 and go IDLE.
REQ-021 COLLECT + colwrite with different rd: commit current buffer with its partial mask next cycle; new column SHALL load a fresh buffer in the same cycle; stay COLLECT.
REQ-022 COLLECT + splat: commit partial buffer next cycle; load splat as full buffer, go DRAIN; DRAIN SHALL commit it the following cycle and return to IDLE. A vector op arriving in DRAIN SHALL be handled as if in IDLE in that cycle (the next FSM state is determined by that op); the DRAIN commit has priority on the port, and the new op's commit follows one cycle later.
REQ-023 Idle counter SHALL count consecutive COLLECT cycles with no vector op; at IDLE_TIMEOUT commit partial buffer and go IDLE; any vector op SHALL clear it.
REQ-024 wb_flush in COLLECT SHALL commit the buffer next cycle; wb_flush coincident with a column op SHALL merge the column first, then commit.
REQ-025 At most one vector commit per cycle SHALL occur; scalar and vector ports SHALL operate independently in the same cycle.
REQ-026 vbusy SHALL equal (state != IDLE).

Reset
REQ-027 rst SHALL asynchronously force state IDLE, buffer and mask 0, idle counter 0, all outputs 0.
REQ-028 Partial buffer contents present at reset SHALL be discarded, never committed.

Structure
REQ-029 wb_pkg SHALL hold the state enum, MemToReg encodings, VLANES and IDLE_TIMEOUT defaults.
REQ-030 Column buffer, mask and merge logic SHALL be sub-module wb_vcol_buffer; the FSM and scalar path SHALL stay in wb_stage.

Verification
REQ-031 Scalar: RegWrite, rd=7, MemToReg=10, sbox=0x63 -> next cycle rf_we=1, waddr=7, wdata=0x63; rd=0 -> no rf_we.
REQ-032 Full column set: colwrite rd=3 columns 0..3 with 0xA0..0xA3 on 4 consecutive cycles -> one vrf_we, waddr=3, mask=1111, wdata={0xA3,0xA2,0xA1,0xA0}.
REQ-033 rd change: columns 0,1 to rd=3 then column 2 to rd=4 -> commit rd=3 mask=0011, vbusy stays high for rd=4.
REQ-034 Timeout: column 1 to rd=5, then 4 idle cycles -> commit rd=5 mask=0010 after the 4th idle cycle.
REQ-035 Splat in COLLECT: column 0 rd=2, then splat rd=6 data 0x1B -> commit rd=2 mask=0001, next cycle rd=6 mask=1111 wdata 0x1B x4.
REQ-036 Reset mid-COLLECT: assert rst with 2 columns pending -> no vrf_we, vbusy=0 immediately.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back stage: FSM states, result-select
// encodings and the internal control codes passed to the column buffer.
package wb_pkg;

  localparam int unsigned VLANES_DEF       = 4;
  localparam int unsigned IDLE_TIMEOUT_DEF = 4;

  localparam logic [1:0] MemToRegAlu  = 2'b00;
  localparam logic [1:0] MemToRegMem  = 2'b01;
  localparam logic [1:0] MemToRegSbox = 2'b10;
  localparam logic [1:0] MemToRegRcon = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain
  } wb_state_e;

  typedef enum logic [2:0] {
    BufHold,
    BufMerge,
    BufLoadCol,
    BufLoadSplat,
    BufClear
  } buf_op_e;

  // Source of the vector write issued at the next edge.
  typedef enum logic [1:0] {
    CmtNone,
    CmtBuf,
    CmtMerged,
    CmtSplat
  } cmt_src_e;

  function automatic logic [31:0] sel_result(input logic [1:0]  sel,
                                             input logic [31:0] alu,
                                             input logic [31:0] mem,
                                             input logic [31:0] sbox,
                                             input logic [31:0] rcon);
    logic [31:0] res;
    unique case (sel)
      MemToRegAlu:  res = alu;
      MemToRegMem:  res = mem;
      MemToRegSbox: res = sbox;
      default:      res = rcon;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_vcol_buffer.sv
// Column buffer for vector write-back: holds lane data, lane mask and target
// register, and exposes the buffer as it would look with the incoming column merged.
module wb_vcol_buffer
  import wb_pkg::*;
#(
  parameter int unsigned VLANES = VLANES_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  buf_op_e                op_i,
  input  logic [1:0]             lane_i,
  input  logic [31:0]            word_i,
  input  logic [4:0]             rd_i,
  output logic [32*VLANES-1:0]   data_o,
  output logic [VLANES-1:0]      mask_o,
  output logic [4:0]             rd_o,
  output logic [32*VLANES-1:0]   merged_data_o,
  output logic [VLANES-1:0]      merged_mask_o,
  output logic                   merged_full_o
);

  localparam int unsigned DataW = 32 * VLANES;

  logic [DataW-1:0]  data_q, data_d;
  logic [VLANES-1:0] mask_q, mask_d;
  logic [4:0]        rd_q, rd_d;

  logic [VLANES-1:0] col_mask;
  logic [DataW-1:0]  col_bits;
  logic [DataW-1:0]  word_rep;

  always_comb begin
    col_mask = '0;
    col_bits = '0;
    for (int l = 0; l < int'(VLANES); l++) begin
      col_mask[l]         = (int'(lane_i) == l);
      col_bits[32*l +: 32] = {32{col_mask[l]}};
    end
  end

  assign word_rep = {VLANES{word_i}};

  // A rewrite of an already-set lane simply overwrites it.
  assign merged_data_o = (data_q & ~col_bits) | (word_rep & col_bits);
  assign merged_mask_o = mask_q | col_mask;
  assign merged_full_o = &merged_mask_o;

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    rd_d   = rd_q;
    unique case (op_i)
      BufMerge: begin
        data_d = merged_data_o;
        mask_d = merged_mask_o;
      end
      BufLoadCol: begin
        data_d = word_rep & col_bits;
        mask_d = col_mask;
        rd_d   = rd_i;
      end
      BufLoadSplat: begin
        data_d = word_rep;
        mask_d = '1;
        rd_d   = rd_i;
      end
      BufClear: begin
        data_d = '0;
        mask_d = '0;
        rd_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      mask_q <= '0;
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      rd_q   <= rd_d;
    end
  end

  assign data_o = data_q;
  assign mask_o = mask_q;
  assign rd_o   = rd_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registered scalar register-file write plus a vector path that
// gathers column writes into a buffer and commits them as masked vector writes.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned VLANES       = VLANES_DEF,
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          WB_MemData,
  input  logic [31:0]          WB_ALUResult,
  input  logic [31:0]          WB_sbox,
  input  logic [31:0]          WB_rcon,
  input  logic [4:0]           WB_rd,
  input  logic [1:0]           WB_MemToReg,
  input  logic                 WB_RegWrite,
  input  logic                 WB_VRegWrite,
  input  logic                 WB_colwrite,
  input  logic [1:0]           WB_columna,
  input  logic                 wb_flush,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 vrf_we,
  output logic [4:0]           vrf_waddr,
  output logic [32*VLANES-1:0] vrf_wdata,
  output logic [VLANES-1:0]    vrf_wmask,
  output logic                 vbusy
);

  localparam int unsigned DataW = 32 * VLANES;
  localparam int unsigned CntW  = $clog2(IDLE_TIMEOUT + 1);

  wb_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  buf_op_e          buf_op;
  cmt_src_e         cmt_src;

  logic [31:0]       result;
  logic              col_op, splat_op;

  logic [DataW-1:0]  buf_data, merged_data;
  logic [VLANES-1:0] buf_mask, merged_mask;
  logic [4:0]        buf_rd;
  logic              merged_full;

  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;
  logic              vrf_we_q, vrf_we_d;
  logic [4:0]        vrf_waddr_q, vrf_waddr_d;
  logic [DataW-1:0]  vrf_wdata_q, vrf_wdata_d;
  logic [VLANES-1:0] vrf_wmask_q, vrf_wmask_d;

  assign result   = sel_result(WB_MemToReg, WB_ALUResult, WB_MemData, WB_sbox, WB_rcon);
  assign col_op   = WB_VRegWrite & WB_colwrite;
  assign splat_op = WB_VRegWrite & ~WB_colwrite;

  wb_vcol_buffer #(
    .VLANES (VLANES)
  ) u_vcol_buffer (
    .clk_i         (clk),
    .rst_i         (rst),
    .op_i          (buf_op),
    .lane_i        (WB_columna),
    .word_i        (result),
    .rd_i          (WB_rd),
    .data_o        (buf_data),
    .mask_o        (buf_mask),
    .rd_o          (buf_rd),
    .merged_data_o (merged_data),
    .merged_mask_o (merged_mask),
    .merged_full_o (merged_full)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_op  = BufHold;
    cmt_src = CmtNone;
    unique case (state_q)
      // DRAIN commits its full buffer and otherwise reacts to the op like IDLE.
      StIdle, StDrain: begin
        cnt_d = '0;
        if (state_q == StDrain) cmt_src = CmtBuf;
        if (col_op) begin
          buf_op  = BufLoadCol;
          state_d = StCollect;
        end else if (splat_op) begin
          if (state_q == StDrain) begin
            buf_op  = BufLoadSplat;
            state_d = StDrain;
          end else begin
            cmt_src = CmtSplat;
          end
        end else begin
          state_d = StIdle;
          if (state_q == StDrain) buf_op = BufClear;
        end
      end
      StCollect: begin
        if (col_op) begin
          cnt_d = '0;
          if (WB_rd == buf_rd) begin
            buf_op = BufMerge;
            if (merged_full || wb_flush) begin
              cmt_src = CmtMerged;
              buf_op  = BufClear;
              state_d = StIdle;
            end
          end else begin
            cmt_src = CmtBuf;
            buf_op  = BufLoadCol;
          end
        end else if (splat_op) begin
          cnt_d   = '0;
          cmt_src = CmtBuf;
          buf_op  = BufLoadSplat;
          state_d = StDrain;
        end else if (wb_flush || (cnt_q + CntW'(1) == CntW'(IDLE_TIMEOUT))) begin
          cnt_d   = '0;
          cmt_src = CmtBuf;
          buf_op  = BufClear;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        buf_op  = BufClear;
      end
    endcase
  end

  always_comb begin
    vrf_we_d    = 1'b0;
    vrf_waddr_d = '0;
    vrf_wdata_d = '0;
    vrf_wmask_d = '0;
    unique case (cmt_src)
      CmtBuf: begin
        vrf_we_d    = 1'b1;
        vrf_waddr_d = buf_rd;
        vrf_wdata_d = buf_data;
        vrf_wmask_d = buf_mask;
      end
      CmtMerged: begin
        vrf_we_d    = 1'b1;
        vrf_waddr_d = buf_rd;
        vrf_wdata_d = merged_data;
        vrf_wmask_d = merged_mask;
      end
      CmtSplat: begin
        vrf_we_d    = 1'b1;
        vrf_waddr_d = WB_rd;
        vrf_wdata_d = {VLANES{result}};
        vrf_wmask_d = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rf_we_d    = WB_RegWrite && (WB_rd != 5'd0);
    rf_waddr_d = rf_we_d ? WB_rd : 5'd0;
    rf_wdata_d = rf_we_d ? result : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      vrf_we_q    <= 1'b0;
      vrf_waddr_q <= '0;
      vrf_wdata_q <= '0;
      vrf_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      vrf_we_q    <= vrf_we_d;
      vrf_waddr_q <= vrf_waddr_d;
      vrf_wdata_q <= vrf_wdata_d;
      vrf_wmask_q <= vrf_wmask_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign vrf_we    = vrf_we_q;
  assign vrf_waddr = vrf_waddr_q;
  assign vrf_wdata = vrf_wdata_q;
  assign vrf_wmask = vrf_wmask_q;
  assign vbusy     = (state_q != StIdle);

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a lane-array model predicts every register-file
// write and the busy flag; a monitor compares them as the DUT presents them.
module tb_wb_stage;

  localparam int IdleTimeout = 4;

  typedef struct {
    int           tag;
    logic [4:0]   addr;
    logic [127:0] data;
    logic [3:0]   mask;
  } vec_exp_t;

  typedef struct {
    int          tag;
    logic [4:0]  addr;
    logic [31:0] data;
  } sc_exp_t;

  typedef struct {
    int   tag;
    logic busy;
  } busy_exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  WB_MemData = '0, WB_ALUResult = '0, WB_sbox = '0, WB_rcon = '0;
  logic [4:0]   WB_rd = '0;
  logic [1:0]   WB_MemToReg = '0;
  logic         WB_RegWrite = 1'b0, WB_VRegWrite = 1'b0, WB_colwrite = 1'b0;
  logic [1:0]   WB_columna = '0;
  logic         wb_flush = 1'b0;
  logic         rf_we, vrf_we, vbusy;
  logic [4:0]   rf_waddr, vrf_waddr;
  logic [31:0]  rf_wdata;
  logic [127:0] vrf_wdata;
  logic [3:0]   vrf_wmask;

  wb_stage #(
    .VLANES       (4),
    .IDLE_TIMEOUT (IdleTimeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .WB_MemData   (WB_MemData),
    .WB_ALUResult (WB_ALUResult),
    .WB_sbox      (WB_sbox),
    .WB_rcon      (WB_rcon),
    .WB_rd        (WB_rd),
    .WB_MemToReg  (WB_MemToReg),
    .WB_RegWrite  (WB_RegWrite),
    .WB_VRegWrite (WB_VRegWrite),
    .WB_colwrite  (WB_colwrite),
    .WB_columna   (WB_columna),
    .wb_flush     (wb_flush),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .vrf_we       (vrf_we),
    .vrf_waddr    (vrf_waddr),
    .vrf_wdata    (vrf_wdata),
    .vrf_wmask    (vrf_wmask),
    .vbusy        (vbusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int        checks = 0;
  int        failures = 0;
  logic      mon_en = 1'b0;
  vec_exp_t  vq[$];
  sc_exp_t   sq[$];
  busy_exp_t bq[$];

  // Reference model: a pending column buffer and a queued full vector awaiting commit.
  logic        m_pend = 1'b0;
  logic        m_drain = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_lane[4];
  logic [3:0]  m_mask = '0;
  int          m_cnt = 0;

  task automatic push_vec(input int tag, input logic [4:0] addr, input logic [3:0] mask);
    vec_exp_t e;
    e.tag  = tag;
    e.addr = addr;
    e.data = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
    e.mask = mask;
    vq.push_back(e);
  endtask

  task automatic load_fresh(input logic [4:0] rd, input logic [1:0] col, input logic [31:0] w);
    for (int l = 0; l < 4; l++) m_lane[l] = 32'd0;
    m_lane[col] = w;
    m_mask      = 4'b0001 << col;
    m_rd        = rd;
    m_pend      = 1'b1;
    m_cnt       = 0;
  endtask

  task automatic load_splat(input logic [4:0] rd, input logic [31:0] w);
    for (int l = 0; l < 4; l++) m_lane[l] = w;
    m_mask  = 4'b1111;
    m_rd    = rd;
    m_pend  = 1'b0;
    m_drain = 1'b1;
  endtask

  task automatic step(input logic rw, input logic vw, input logic cw, input logic [1:0] col,
                      input logic [1:0] sel, input logic [4:0] rd, input logic fl,
                      input logic [31:0] w);
    int      tag;
    logic    colop, splat;
    sc_exp_t se;
    busy_exp_t be;
    @(negedge clk);
    WB_ALUResult = $urandom;
    WB_MemData   = $urandom;
    WB_sbox      = $urandom;
    WB_rcon      = $urandom;
    case (sel)
      2'd0:    WB_ALUResult = w;
      2'd1:    WB_MemData   = w;
      2'd2:    WB_sbox      = w;
      default: WB_rcon      = w;
    endcase
    WB_MemToReg  = sel;
    WB_RegWrite  = rw;
    WB_VRegWrite = vw;
    WB_colwrite  = cw;
    WB_columna   = col;
    WB_rd        = rd;
    wb_flush     = fl;
    tag   = cyc + 1;
    colop = vw && cw;
    splat = vw && !cw;
    if (rw && rd != 5'd0) begin
      se.tag = tag; se.addr = rd; se.data = w;
      sq.push_back(se);
    end
    if (m_drain) begin
      push_vec(tag, m_rd, m_mask);
      m_drain = 1'b0;
      if (colop) load_fresh(rd, col, w);
      else if (splat) load_splat(rd, w);
    end else if (m_pend) begin
      if (colop) begin
        m_cnt = 0;
        if (rd == m_rd) begin
          m_lane[col] = w;
          m_mask[col] = 1'b1;
          if (m_mask == 4'b1111 || fl) begin
            push_vec(tag, m_rd, m_mask);
            m_pend = 1'b0;
          end
        end else begin
          push_vec(tag, m_rd, m_mask);
          load_fresh(rd, col, w);
        end
      end else if (splat) begin
        push_vec(tag, m_rd, m_mask);
        m_cnt = 0;
        load_splat(rd, w);
      end else begin
        m_cnt = m_cnt + 1;
        if (fl || m_cnt == IdleTimeout) begin
          push_vec(tag, m_rd, m_mask);
          m_pend = 1'b0;
          m_cnt  = 0;
        end
      end
    end else if (colop) begin
      load_fresh(rd, col, w);
    end else if (splat) begin
      for (int l = 0; l < 4; l++) m_lane[l] = w;
      push_vec(tag, rd, 4'b1111);
    end
    be.tag = tag; be.busy = m_pend || m_drain;
    bq.push_back(be);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic col_wr(input logic [4:0] rd, input logic [1:0] col, input logic [31:0] w);
    step(1'b0, 1'b1, 1'b1, col, 2'd0, rd, 1'b0, w);
  endtask

  task automatic monitor();
    vec_exp_t  ve;
    sc_exp_t   se;
    busy_exp_t be;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        checks++;
        if (vq.size() > 0 && vq[0].tag == cyc) begin
          ve = vq.pop_front();
          if (vrf_we !== 1'b1 || vrf_waddr !== ve.addr || vrf_wdata !== ve.data ||
              vrf_wmask !== ve.mask) begin
            failures++;
            $display("FAIL vec_commit cyc=%0d got we=%b addr=%0d mask=%b data=%h want addr=%0d mask=%b data=%h",
                     cyc, vrf_we, vrf_waddr, vrf_wmask, vrf_wdata, ve.addr, ve.mask, ve.data);
          end
        end else if (vrf_we !== 1'b0) begin
          failures++;
          $display("FAIL vec_spurious cyc=%0d got we=%b addr=%0d mask=%b want we=0",
                   cyc, vrf_we, vrf_waddr, vrf_wmask);
        end
        checks++;
        if (sq.size() > 0 && sq[0].tag == cyc) begin
          se = sq.pop_front();
          if (rf_we !== 1'b1 || rf_waddr !== se.addr || rf_wdata !== se.data) begin
            failures++;
            $display("FAIL rf_write cyc=%0d got we=%b addr=%0d data=%h want addr=%0d data=%h",
                     cyc, rf_we, rf_waddr, rf_wdata, se.addr, se.data);
          end
        end else if (rf_we !== 1'b0) begin
          failures++;
          $display("FAIL rf_spurious cyc=%0d got we=%b addr=%0d want we=0", cyc, rf_we, rf_waddr);
        end
        if (bq.size() > 0 && bq[0].tag == cyc) begin
          be = bq.pop_front();
          checks++;
          if (vbusy !== be.busy) begin
            failures++;
            $display("FAIL vbusy cyc=%0d got %b want %b", cyc, vbusy, be.busy);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    for (int l = 0; l < 4; l++) m_lane[l] = 32'd0;
    @(posedge clk);
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, vrf_we, vrf_waddr, vrf_wdata, vrf_wmask, vbusy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rf_we=%b vrf_we=%b vbusy=%b want all zero", rf_we, vrf_we, vbusy);
    end
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Scalar write, then rd=0 dropped.
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 5'd7, 1'b0, 32'h63);
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 5'd0, 1'b0, 32'h55);
    idle(1);
    // Full column set.
    for (int c = 0; c < 4; c++) col_wr(5'd3, 2'(c), 32'hA0 + 32'(c));
    idle(2);
    // rd change then timeout of the new buffer.
    col_wr(5'd3, 2'd0, 32'h11);
    col_wr(5'd3, 2'd1, 32'h22);
    col_wr(5'd4, 2'd2, 32'h33);
    idle(6);
    // Timeout on a single column.
    col_wr(5'd5, 2'd1, 32'h44);
    idle(6);
    // Splat in COLLECT, then splat in DRAIN, then column in DRAIN.
    col_wr(5'd2, 2'd0, 32'h77);
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 5'd6, 1'b0, 32'h1B);
    step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 5'd8, 1'b0, 32'hC3);
    col_wr(5'd9, 2'd3, 32'h99);
    idle(6);
    // Flush coincident with a column op, and lane overwrite.
    col_wr(5'd10, 2'd2, 32'h01);
    col_wr(5'd10, 2'd2, 32'h02);
    step(1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 5'd10, 1'b1, 32'h03);
    col_wr(5'd11, 2'd0, 32'h04);
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 1'b1, 32'h0);
    // Splat from IDLE.
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 5'd12, 1'b0, 32'hDEAD_BEEF);
    idle(2);

    // Reset with two columns pending: nothing may be committed.
    col_wr(5'd13, 2'd0, 32'h5);
    col_wr(5'd13, 2'd1, 32'h6);
    @(negedge clk);
    mon_en       = 1'b0;
    WB_VRegWrite = 1'b0;
    WB_RegWrite  = 1'b0;
    wb_flush     = 1'b0;
    rst          = 1'b1;
    #1;
    checks++;
    if (vbusy !== 1'b0 || vrf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_collect got vbusy=%b vrf_we=%b want 0 0", vbusy, vrf_we);
    end
    vq.delete(); sq.delete(); bq.delete();
    m_pend = 1'b0; m_drain = 1'b0; m_mask = '0; m_cnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (vrf_we !== 1'b0 || vbusy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold got vrf_we=%b vbusy=%b want 0 0", vrf_we, vbusy);
      end
    end
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(IdleTimeout + 2);

    for (int i = 0; i < 800; i++) begin
      logic vw;
      vw = ($urandom_range(0, 9) < 6) && ((i % 60) < 45);
      step(1'($urandom_range(0, 1)), vw, ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
           $urandom);
    end
    idle(IdleTimeout + 3);
    @(negedge clk);
    checks++;
    if (vq.size() != 0 || sq.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got vec=%0d rf=%0d outstanding want 0 0", vq.size(), sq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
